// File: rtl/polyphase_mux4_dac_teg.sv
// polyphase_mux4_dac_teg: 4:1 re-serializer for the DAC test path.
// A 4-lane frame enters through a one-deep holding buffer, moves to a shift
// buffer, and leaves one sample per CLK in serial order IN1, IN3, IN2, IN4.
// This order undoes the two-level 1:4 ADC demux tree. Frames run back to
// back with no gap while frames keep arriving. If ENABLE is high at a frame
// boundary and no frame is waiting, the block raises the sticky UNDERRUN flag.
module polyphase_mux4_dac_teg #(
    parameter int BW = 6
) (
    input  logic                 CLK,
    input  logic                 RES,
    input  logic                 ENABLE,
    input  logic signed [BW-1:0] IN1,
    input  logic signed [BW-1:0] IN2,
    input  logic signed [BW-1:0] IN3,
    input  logic signed [BW-1:0] IN4,
    input  logic                 IN_VALID,
    output logic                 IN_READY,
    output logic signed [BW-1:0] OUT,
    output logic                 OUT_VALID,
    output logic [1:0]           PHASE,
    output logic                 UNDERRUN
);

    localparam logic [0:0] st_idle = 1'b0;
    localparam logic [0:0] st_run  = 1'b1;

    logic [0:0]           state;
    logic                 hold_full;
    // Both buffers are stored in serial order: slot p is emitted at PHASE p.
    logic signed [BW-1:0] hold_buf  [4];
    logic signed [BW-1:0] shift_buf [4];
    logic                 accept;
    logic                 frame_end;
    logic                 transfer;
    logic [1:0]           next_phase;

    // IN_READY is low while RES is high, so no frame is accepted on a reset edge.
    assign IN_READY   = !hold_full && !RES;
    assign accept     = IN_VALID && IN_READY;
    // A new frame may start from IDLE, or on the edge that leaves PHASE=3.
    assign frame_end  = (state == st_idle) || (PHASE == 2'd3);
    assign transfer   = frame_end && ENABLE && hold_full;
    assign next_phase = PHASE + 2'd1;

    // Holding buffer occupancy: set on accept, cleared when the frame moves to the shift buffer.
    always_ff @(posedge CLK) begin
        // NOTE: non-blocking assignments keep every flop reading pre-edge values, whatever the block order.
        if (RES) begin
            hold_full <= 1'b0;
        end else if (accept) begin
            hold_full <= 1'b1;
        end else if (transfer) begin
            hold_full <= 1'b0;
        end
    end

    // Holding buffer data: capture the lanes in serial order when a frame is accepted.
    always_ff @(posedge CLK) begin
        // NOTE: the data needs no reset; hold_full tells whether the contents are meaningful.
        if (accept) begin
            hold_buf[0] <= IN1;
            hold_buf[1] <= IN3;
            hold_buf[2] <= IN2;
            hold_buf[3] <= IN4;
        end
    end

    // Serializer: load a frame, step through its 4 phases, then decide between next frame, stop and underrun.
    always_ff @(posedge CLK) begin
        if (RES) begin
            state     <= st_idle;
            OUT       <= '0;
            OUT_VALID <= 1'b0;
            PHASE     <= 2'd0;
            UNDERRUN  <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                shift_buf[i] <= '0;
            end
        end else if (transfer) begin
            state     <= st_run;
            shift_buf <= hold_buf;
            OUT       <= hold_buf[0];
            OUT_VALID <= 1'b1;
            PHASE     <= 2'd0;
        end else if (state == st_run) begin
            if (PHASE != 2'd3) begin
                OUT   <= shift_buf[next_phase];
                PHASE <= next_phase;
            end else begin
                // Frame boundary with no transfer: either ENABLE dropped or no frame is waiting.
                state     <= st_idle;
                OUT       <= '0;
                OUT_VALID <= 1'b0;
                PHASE     <= 2'd0;
                if (ENABLE) begin
                    UNDERRUN <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_polyphase_mux4_dac_teg.sv
// Testbench for polyphase_mux4_dac_teg.
// The reference model works at the sample-stream level. It keeps a queue of
// samples still to be emitted and a one-deep waiting frame. The bench
// compares the DUT against this model every cycle, and each scenario adds
// checks with fixed expected values.
module tb_polyphase_mux4_dac_teg;

    localparam int BW = 6;

    logic                 clk;
    logic                 res;
    logic                 enable;
    logic signed [BW-1:0] in1, in2, in3, in4;
    logic                 in_valid;
    logic                 in_ready;
    logic signed [BW-1:0] out;
    logic                 out_valid;
    logic [1:0]           phase;
    logic                 underrun;

    int checks = 0;
    int errors = 0;

    polyphase_mux4_dac_teg #(.BW(BW)) dut (
        .CLK      (clk),
        .RES      (res),
        .ENABLE   (enable),
        .IN1      (in1),
        .IN2      (in2),
        .IN3      (in3),
        .IN4      (in4),
        .IN_VALID (in_valid),
        .IN_READY (in_ready),
        .OUT      (out),
        .OUT_VALID(out_valid),
        .PHASE    (phase),
        .UNDERRUN (underrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    typedef struct {
        logic signed [BW-1:0] v;
        logic [1:0]           ph;
        int                   fid;
    } samp_t;

    samp_t                q[$];
    bit                   m_held;
    logic signed [BW-1:0] m_lane [4];   // lane order IN1..IN4
    int                   m_hold_id;
    logic signed [BW-1:0] m_out;
    bit                   m_valid;
    logic [1:0]           m_phase;
    bit                   m_under;
    int                   m_fid;
    int                   acc_count = 0;
    int                   order [4] = '{0, 2, 1, 3};  // serial position -> lane index

    // One clock edge of the model, using the inputs the DUT sampled at that edge.
    task automatic model_edge();
        bit    acc;
        samp_t s;
        if (res) begin
            q.delete();
            m_held  = 0;
            m_out   = '0;
            m_valid = 0;
            m_phase = 2'd0;
            m_under = 0;
            m_fid   = 0;
            return;
        end
        acc = in_valid && !m_held;
        if (q.size() == 0) begin
            if (enable && m_held) begin
                for (int p = 0; p < 4; p++) begin
                    s.v   = m_lane[order[p]];
                    s.ph  = 2'(p);
                    s.fid = m_hold_id;
                    q.push_back(s);
                end
                m_held = 0;
            end else if (enable && m_valid) begin
                m_under = 1;
            end
        end
        if (q.size() != 0) begin
            s       = q.pop_front();
            m_out   = s.v;
            m_phase = s.ph;
            m_fid   = s.fid;
            m_valid = 1;
        end else begin
            m_out   = '0;
            m_phase = 2'd0;
            m_valid = 0;
        end
        if (acc) begin
            m_held    = 1;
            m_lane    = '{in1, in2, in3, in4};
            acc_count++;
            m_hold_id = acc_count;
        end
    endtask

    function automatic logic [BW+4:0] exp_vec();
        return {!m_held && !res, m_under, m_valid, m_phase, m_out};
    endfunction

    function automatic logic [BW+4:0] obs_vec();
        return {in_ready, underrun, out_valid, phase, out};
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic rand_frame();
        logic [31:0] r;
        r   = $urandom;
        in1 = r[5:0];
        in2 = r[11:6];
        in3 = r[17:12];
        in4 = r[23:18];
    endtask

    task automatic do_reset();
        res      = 1'b1;
        enable   = 1'b0;
        in_valid = 1'b0;
        tick();
        tick();
        res = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        res      = 1'b1;
        enable   = 1'b0;
        in_valid = 1'b0;
        rand_frame();
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL reset cycle %0d: got %h want %h", i, obs_vec(), exp_vec());
            end
        end
        res = 1'b0;
        #1;
        checks++;
        if ({in_ready, underrun, out_valid, phase, out} !== {1'b1, 1'b0, 1'b0, 2'd0, 6'd0}) begin
            errors++;
            $display("FAIL reset_release: got rdy=%b und=%b vld=%b ph=%0d out=%0d want rdy=1 und=0 vld=0 ph=0 out=0",
                     in_ready, underrun, out_valid, phase, out);
        end
    endtask

    task automatic test_single_frame();
        logic signed [BW-1:0] seq [4];
        seq[0] = 6'sd1;
        seq[1] = 6'sd2;
        seq[2] = 6'sd3;
        seq[3] = 6'b100000;
        do_reset();
        enable   = 1'b1;
        in_valid = 1'b1;
        in1 = 6'sd1;
        in2 = 6'sd3;
        in3 = 6'sd2;
        in4 = 6'b100000;
        tick();
        checks++;
        if (obs_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL single_accept: got %h want %h", obs_vec(), exp_vec());
        end
        in_valid = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            tick();
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL single_model edge k+%0d: got %h want %h", i, obs_vec(), exp_vec());
            end
            checks++;
            if (i <= 4) begin
                if (out !== seq[i-1] || phase !== 2'(i-1) || out_valid !== 1'b1) begin
                    errors++;
                    $display("FAIL single_seq edge k+%0d: got out=%0d ph=%0d vld=%b want out=%0d ph=%0d vld=1",
                             i, out, phase, out_valid, seq[i-1], i-1);
                end
            end else if (out_valid !== 1'b0 || underrun !== 1'b1) begin
                errors++;
                $display("FAIL single_end: got vld=%b und=%b want vld=0 und=1", out_valid, underrun);
            end
        end
    endtask

    task automatic test_back_to_back();
        int base, run, maxrun, vtot;
        do_reset();
        enable = 1'b1;
        base   = acc_count;
        run    = 0;
        maxrun = 0;
        vtot   = 0;
        for (int c = 0; c < 60; c++) begin
            if (acc_count - base < 8) begin
                in_valid = 1'b1;
                rand_frame();
            end else begin
                in_valid = 1'b0;
            end
            tick();
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL stream cycle %0d: got %h want %h", c, obs_vec(), exp_vec());
            end
            if (out_valid === 1'b1) begin
                run++;
                vtot++;
            end else begin
                run = 0;
            end
            if (run > maxrun) maxrun = run;
        end
        checks++;
        if (maxrun != 32 || vtot != 32 || underrun !== 1'b1) begin
            errors++;
            $display("FAIL stream_gapless: got run=%0d total=%0d und=%b want run=32 total=32 und=1",
                     maxrun, vtot, underrun);
        end
    endtask

    task automatic test_graceful_stop();
        int base, vcount;
        bit dropped;
        do_reset();
        enable  = 1'b1;
        base    = acc_count;
        dropped = 0;
        for (int c = 0; c < 30; c++) begin
            if (acc_count - base < 3) begin
                in_valid = 1'b1;
                rand_frame();
            end else begin
                in_valid = 1'b0;
            end
            if (!dropped && m_valid && m_fid == base + 2 && m_phase == 2'd1) begin
                enable  = 1'b0;
                dropped = 1;
            end
            tick();
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL stop cycle %0d: got %h want %h", c, obs_vec(), exp_vec());
            end
        end
        checks++;
        if (!dropped || in_ready !== 1'b0 || underrun !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL stop_idle: got drop=%0d rdy=%b und=%b vld=%b want drop=1 rdy=0 und=0 vld=0",
                     dropped, in_ready, underrun, out_valid);
        end
        enable = 1'b1;
        vcount = 0;
        for (int c = 0; c < 6; c++) begin
            tick();
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL resume cycle %0d: got %h want %h", c, obs_vec(), exp_vec());
            end
            if (out_valid === 1'b1) vcount++;
        end
        checks++;
        if (vcount != 4) begin
            errors++;
            $display("FAIL resume_count: got %0d want 4", vcount);
        end
    endtask

    task automatic test_backpressure();
        logic signed [BW-1:0] f [4];
        int vcount;
        do_reset();
        enable   = 1'b0;
        in_valid = 1'b1;
        rand_frame();
        f = '{in1, in3, in2, in4};   // expected serial order of the accepted frame
        for (int c = 0; c < 6; c++) begin
            tick();
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL bp_hold cycle %0d: got %h want %h", c, obs_vec(), exp_vec());
            end
            rand_frame();
        end
        in_valid = 1'b0;
        enable   = 1'b1;
        vcount   = 0;
        for (int c = 0; c < 7; c++) begin
            tick();
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL bp_emit cycle %0d: got %h want %h", c, obs_vec(), exp_vec());
            end
            if (out_valid === 1'b1) begin
                checks++;
                if (vcount > 3 || out !== f[vcount]) begin
                    errors++;
                    $display("FAIL bp_data sample %0d: got %0d want %0d", vcount, out, f[vcount & 3]);
                end
                vcount++;
            end
        end
        checks++;
        if (vcount != 4) begin
            errors++;
            $display("FAIL bp_count: got %0d want 4", vcount);
        end
    endtask

    task automatic test_reset_mid_frame();
        int base;
        bit found;
        do_reset();
        enable = 1'b1;
        base   = acc_count;
        found  = 0;
        for (int c = 0; c < 20 && !found; c++) begin
            if (acc_count - base < 2) begin
                in_valid = 1'b1;
                rand_frame();
            end else begin
                in_valid = 1'b0;
            end
            tick();
            if (m_valid && m_phase == 2'd2 && m_held) found = 1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL midreset_setup: got no PHASE=2 with pending frame want one");
        end
        res      = 1'b1;
        in_valid = 1'b0;
        tick();
        checks++;
        if (obs_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL midreset_edge: got %h want %h", obs_vec(), exp_vec());
        end
        res = 1'b0;
        #1;
        checks++;
        if ({in_ready, out_valid, out} !== {1'b1, 1'b0, 6'd0}) begin
            errors++;
            $display("FAIL midreset_release: got rdy=%b vld=%b out=%0d want rdy=1 vld=0 out=0",
                     in_ready, out_valid, out);
        end
        for (int c = 0; c < 8; c++) begin
            tick();
            checks++;
            if (obs_vec() !== exp_vec() || out_valid !== 1'b0) begin
                errors++;
                $display("FAIL midreset_quiet cycle %0d: got %h want %h", c, obs_vec(), exp_vec());
            end
        end
    endtask

    initial begin
        res      = 1'b1;
        enable   = 1'b0;
        in_valid = 1'b0;
        in1 = '0;
        in2 = '0;
        in3 = '0;
        in4 = '0;
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_graceful_stop();
        test_backpressure();
        test_reset_mid_frame();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
